// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU operation sequencer.
// Holds the sequencer state encoding and the register-enable patterns.
package alu_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } alu_seq_state_t;

  localparam logic [2:0] REG_EN_ALL  = 3'b111;
  localparam logic [2:0] REG_EN_NONE = 3'b000;

endpackage

// File: rtl/alu_seq_wait_ctr.sv
// Loadable down-counter that times the ALU latency window.
// The zero flag marks the cycle in which the ALU result is valid.
module alu_seq_wait_ctr #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec) begin
      count <= count - WIDTH'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/alu_op_sequencer.sv
// Control front end for the ALU: one operation in flight, operands held
// stable from acceptance until the response is consumed.
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int BUS_WIDTH = 8,
  parameter int ALU_LAT   = 1,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [BUS_WIDTH-1:0] in_a,
  input  logic [BUS_WIDTH-1:0] in_b,
  input  logic [BUS_WIDTH-1:0] in_imm,
  input  logic                 in_add,
  output logic [BUS_WIDTH-1:0] alu_data_a,
  output logic [BUS_WIDTH-1:0] alu_data_b,
  output logic [BUS_WIDTH-1:0] alu_imm,
  output logic                 alu_f_add,
  output logic [2:0]           alu_reg_en,
  input  logic [BUS_WIDTH-1:0] alu_result,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [BUS_WIDTH-1:0] out_data,
  output logic [CNT_WIDTH-1:0] op_count
);

  localparam int CTR_W = $clog2(ALU_LAT + 1);
  localparam logic [CTR_W-1:0] WAIT_INIT = CTR_W'(ALU_LAT - 1);

  alu_seq_state_t state;
  logic [BUS_WIDTH-1:0] a_q, b_q, imm_q;
  logic add_q;
  logic ctr_load, ctr_dec, ctr_zero;

  assign in_ready   = (state == IDLE);
  assign alu_data_a = a_q;
  assign alu_data_b = b_q;
  assign alu_imm    = imm_q;
  assign alu_f_add  = add_q;

  // The counter is loaded as LOAD ends so WAIT starts at ALU_LAT-1.
  assign ctr_load = (state == LOAD);
  assign ctr_dec  = (state == WAIT) && !ctr_zero;

  alu_seq_wait_ctr #(
    .WIDTH(CTR_W)
  ) u_wait_ctr (
    .clk     (clk),
    .rst     (rst),
    .load    (ctr_load),
    .load_val(WAIT_INIT),
    .dec     (ctr_dec),
    .zero    (ctr_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      a_q        <= '0;
      b_q        <= '0;
      imm_q      <= '0;
      add_q      <= 1'b0;
      alu_reg_en <= REG_EN_NONE;
      out_valid  <= 1'b0;
      out_data   <= '0;
      op_count   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q        <= in_a;
            b_q        <= in_b;
            imm_q      <= in_imm;
            add_q      <= in_add;
            alu_reg_en <= REG_EN_ALL;
            state      <= LOAD;
          end
        end
        LOAD: begin
          alu_reg_en <= REG_EN_NONE;
          state      <= WAIT;
        end
        WAIT: begin
          if (ctr_zero) begin
            out_data  <= alu_result;
            out_valid <= 1'b1;
            state     <= HOLD;
          end
        end
        HOLD: begin
          // Completion returns to IDLE only; a waiting request is taken next edge.
          if (out_ready) begin
            out_valid <= 1'b0;
            op_count  <= op_count + CNT_WIDTH'(1);
            state     <= IDLE;
          end
        end
        default: begin
          alu_reg_en <= REG_EN_NONE;
          out_valid  <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: two instances (ALU_LAT=1 and ALU_LAT=3/CNT_WIDTH=4)
// share stimulus, each backed by an ALU stub and a cycle-age reference model.
module tb_alu_op_sequencer;

  localparam int LAT1 = 1;
  localparam int LAT3 = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic in_valid = 1'b0;
  logic [7:0] in_a = '0, in_b = '0, in_imm = '0;
  logic in_add = 1'b0;
  logic out_ready = 1'b0;

  logic in_ready1, f_add1, out_valid1;
  logic [7:0] data_a1, data_b1, imm1, result1, out_data1;
  logic [2:0] reg_en1;
  logic [15:0] op_count1;

  logic in_ready3, f_add3, out_valid3;
  logic [7:0] data_a3, data_b3, imm3, result3, out_data3;
  logic [2:0] reg_en3;
  logic [3:0] op_count3;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc1[$];
  int acc3[$];
  int comp3 = 0;

  always #5 clk = ~clk;

  alu_op_sequencer #(.BUS_WIDTH(8), .ALU_LAT(LAT1), .CNT_WIDTH(16)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
    .in_a(in_a), .in_b(in_b), .in_imm(in_imm), .in_add(in_add),
    .alu_data_a(data_a1), .alu_data_b(data_b1), .alu_imm(imm1),
    .alu_f_add(f_add1), .alu_reg_en(reg_en1), .alu_result(result1),
    .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1),
    .op_count(op_count1)
  );

  alu_op_sequencer #(.BUS_WIDTH(8), .ALU_LAT(LAT3), .CNT_WIDTH(4)) dut3 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready3),
    .in_a(in_a), .in_b(in_b), .in_imm(in_imm), .in_add(in_add),
    .alu_data_a(data_a3), .alu_data_b(data_b3), .alu_imm(imm3),
    .alu_f_add(f_add3), .alu_reg_en(reg_en3), .alu_result(result3),
    .out_valid(out_valid3), .out_ready(out_ready), .out_data(out_data3),
    .op_count(op_count3)
  );

  // ALU stubs: sum is taken on reg_en=111 and emerges ALU_LAT cycles later;
  // any other cycle pushes a junk value so early or late capture is visible.
  logic [7:0] pipe1 [1];
  logic [7:0] pipe3 [3];
  always @(posedge clk) begin
    pipe1[0] <= (reg_en1 == 3'b111) ? 8'(data_a1 + data_b1 + imm1) : 8'hEE;
    pipe3[0] <= (reg_en3 == 3'b111) ? 8'(data_a3 + data_b3 + imm3) : 8'hEE;
    pipe3[1] <= pipe3[0];
    pipe3[2] <= pipe3[1];
  end
  assign result1 = pipe1[0];
  assign result3 = pipe3[2];

  // Reference model: an operation is tracked by its age in cycles since acceptance.
  typedef struct {
    bit         busy;
    int         age;
    logic [7:0] a, b, imm;
    bit         add;
    logic [7:0] data;
    int         count;
  } model_t;

  model_t m [2];

  function automatic model_t model_next(model_t c, int lat, int mask);
    model_t n = c;
    if (!c.busy) begin
      if (in_valid) begin
        n.busy = 1'b1;
        n.age  = 1;
        n.a    = in_a;
        n.b    = in_b;
        n.imm  = in_imm;
        n.add  = in_add;
      end
    end else if (c.age >= lat + 2) begin
      if (out_ready) begin
        n.busy  = 1'b0;
        n.count = (c.count + 1) & mask;
      end
    end else begin
      n.age = c.age + 1;
      if (n.age == lat + 2) n.data = 8'(c.a + c.b + c.imm);
    end
    return n;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m[0] <= '{default: 0};
      m[1] <= '{default: 0};
    end else begin
      m[0] <= model_next(m[0], LAT1, 32'hFFFF);
      m[1] <= model_next(m[1], LAT3, 32'hF);
    end
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst) begin
      if (in_valid && in_ready1) acc1.push_back(cyc);
      if (in_valid && in_ready3) acc3.push_back(cyc);
      if (out_valid3 && out_ready) comp3 <= comp3 + 1;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [7:0] a, input logic [7:0] b,
                               input logic [7:0] imm, input logic add);
    in_valid = v;
    in_a     = a;
    in_b     = b;
    in_imm   = imm;
    in_add   = add;
  endtask

  task automatic wait_idle(input int max_cycles);
    int n = 0;
    while (!(in_ready1 && in_ready3 && !out_valid1 && !out_valid3) && n < max_cycles) begin
      @(negedge clk);
      n++;
    end
    checkOutput("idle_timeout", 32'(n < max_cycles), 32'd1);
  endtask

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    checkOutput("d1_in_ready", 32'(in_ready1), 32'(!m[0].busy));
    checkOutput("d1_reg_en", 32'(reg_en1), (m[0].busy && m[0].age == 1) ? 32'd7 : 32'd0);
    checkOutput("d1_out_valid", 32'(out_valid1), 32'(m[0].busy && m[0].age >= LAT1 + 2));
    checkOutput("d1_out_data", 32'(out_data1), 32'(m[0].data));
    checkOutput("d1_op_count", 32'(op_count1), 32'(m[0].count));
    checkOutput("d1_data_a", 32'(data_a1), 32'(m[0].a));
    checkOutput("d1_data_b", 32'(data_b1), 32'(m[0].b));
    checkOutput("d1_imm", 32'(imm1), 32'(m[0].imm));
    checkOutput("d1_f_add", 32'(f_add1), 32'(m[0].add));
    checkOutput("d3_in_ready", 32'(in_ready3), 32'(!m[1].busy));
    checkOutput("d3_reg_en", 32'(reg_en3), (m[1].busy && m[1].age == 1) ? 32'd7 : 32'd0);
    checkOutput("d3_out_valid", 32'(out_valid3), 32'(m[1].busy && m[1].age >= LAT3 + 2));
    checkOutput("d3_out_data", 32'(out_data3), 32'(m[1].data));
    checkOutput("d3_op_count", 32'(op_count3), 32'(m[1].count));
    checkOutput("d3_data_a", 32'(data_a3), 32'(m[1].a));
    checkOutput("d3_f_add", 32'(f_add3), 32'(m[1].add));
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int base1, base3, cbase3, n;
    bit seen15;

    // Reset and idle values
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rst_in_ready", 32'(in_ready1), 32'd1);
    checkOutput("rst_out_valid", 32'(out_valid1), 32'd0);
    checkOutput("rst_out_data", 32'(out_data1), 32'h00);
    checkOutput("rst_op_count", 32'(op_count1), 32'd0);
    checkOutput("rst_reg_en", 32'(reg_en1), 32'd0);

    // Reset asserted while the ALU_LAT=3 instance sits in WAIT
    out_ready = 1'b1;
    applyStimulus(1'b1, 8'h01, 8'h02, 8'h03, 1'b0);
    @(negedge clk);
    applyStimulus(1'b0, 8'h01, 8'h02, 8'h03, 1'b0);
    @(negedge clk);
    checkOutput("wait_in_ready", 32'(in_ready3), 32'd0);
    checkOutput("wait_reg_en", 32'(reg_en3), 32'd0);
    @(posedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    checkOutput("midrst_out_valid", 32'(out_valid3), 32'd0);
    checkOutput("midrst_in_ready", 32'(in_ready3), 32'd1);
    checkOutput("midrst_op_count", 32'(op_count3), 32'd0);
    rst = 1'b0;
    repeat (6) begin
      @(negedge clk);
      checkOutput("midrst_no_resp3", 32'(out_valid3), 32'd0);
      checkOutput("midrst_no_resp1", 32'(out_valid1), 32'd0);
    end

    // Basic operation, ALU_LAT=1: 5+3+2 = 0x0A three cycles after acceptance
    applyStimulus(1'b1, 8'h05, 8'h03, 8'h02, 1'b1);
    @(negedge clk);
    applyStimulus(1'b0, 8'h05, 8'h03, 8'h02, 1'b1);
    checkOutput("load_reg_en", 32'(reg_en1), 32'd7);
    checkOutput("load_f_add", 32'(f_add1), 32'd1);
    @(negedge clk);
    checkOutput("wait_reg_en_off", 32'(reg_en1), 32'd0);
    checkOutput("wait_no_valid", 32'(out_valid1), 32'd0);
    @(negedge clk);
    checkOutput("basic_out_valid", 32'(out_valid1), 32'd1);
    checkOutput("basic_out_data", 32'(out_data1), 32'h0A);
    @(negedge clk);
    checkOutput("basic_op_count", 32'(op_count1), 32'd1);
    checkOutput("basic_done_ready", 32'(in_ready1), 32'd1);
    wait_idle(20);

    // Backpressure: response held, second request ignored
    out_ready = 1'b0;
    applyStimulus(1'b1, 8'h10, 8'h20, 8'h01, 1'b0);
    @(negedge clk);
    applyStimulus(1'b0, 8'h10, 8'h20, 8'h01, 1'b0);
    n = 0;
    while (!out_valid1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    checkOutput("bp_valid_timeout", 32'(n < 10), 32'd1);
    applyStimulus(1'b1, 8'h77, 8'h66, 8'h55, 1'b1);
    repeat (5) begin
      @(negedge clk);
      checkOutput("bp_out_valid", 32'(out_valid1), 32'd1);
      checkOutput("bp_out_data", 32'(out_data1), 32'h31);
      checkOutput("bp_in_ready", 32'(in_ready1), 32'd0);
      checkOutput("bp_data_a", 32'(data_a1), 32'h10);
    end
    applyStimulus(1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
    out_ready = 1'b1;
    wait_idle(20);

    // Back-to-back with out_ready high; FF+01+00 wraps to 00
    base1 = acc1.size();
    base3 = acc3.size();
    applyStimulus(1'b1, 8'hFF, 8'h01, 8'h00, 1'b0);
    n = 0;
    while (acc3.size() - base3 < 3 && n < 40) begin
      @(negedge clk);
      if (out_valid3) checkOutput("b2b_wrap_data", 32'(out_data3), 32'h00);
      n++;
    end
    checkOutput("b2b_timeout", 32'(n < 40), 32'd1);
    applyStimulus(1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
    if (acc3.size() - base3 >= 3) begin
      checkOutput("b2b_gap3_a", 32'(acc3[base3+1] - acc3[base3]), 32'd6);
      checkOutput("b2b_gap3_b", 32'(acc3[base3+2] - acc3[base3+1]), 32'd6);
    end
    if (acc1.size() - base1 >= 2)
      checkOutput("b2b_gap1", 32'(acc1[base1+1] - acc1[base1]), 32'd4);
    wait_idle(20);

    // Counter wrap on the CNT_WIDTH=4 instance after 16 completions
    @(posedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    base3  = acc3.size();
    cbase3 = comp3;
    seen15 = 1'b0;
    applyStimulus(1'b1, 8'h11, 8'h22, 8'h33, 1'b1);
    n = 0;
    while (acc3.size() - base3 < 16 && n < 200) begin
      @(negedge clk);
      if (comp3 - cbase3 == 15 && !seen15) begin
        checkOutput("wrap_count15", 32'(op_count3), 32'd15);
        seen15 = 1'b1;
      end
      n++;
    end
    checkOutput("wrap_timeout", 32'(n < 200), 32'd1);
    applyStimulus(1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
    wait_idle(20);
    checkOutput("wrap_completions", 32'(comp3 - cbase3), 32'd16);
    checkOutput("wrap_op_count", 32'(op_count3), 32'd0);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
